// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the seven-segment scan capture receiver.
//   NUM_DIGITS : number of multiplexed digits on the bus
//   GLYPHS     : active-low cx[7:1] (CA..CG) patterns for hex values 0..F,
//                indexed by the nibble value
//   state_t    : capture FSM states
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-low segment patterns, CA on bit 6 ... CG on bit 0.
    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    // Element i holds the glyph for value i.
    localparam logic [15:0][6:0] GLYPHS = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // True when exactly one anode line is driven low.
    function automatic logic an_one_hot_low(input logic [NUM_DIGITS-1:0] an);
        return $onehot(~an);
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// -----------------------------------------------------------------------------
// seg7_glyph_decode
// Combinational reverse lookup of an active-low CA..CG pattern to a hex nibble.
//   pattern : in  7  cx[7:1], CA on bit 6
//   nibble  : out 4  matched value, 0 when no glyph matches
//   hit     : out 1  pattern is one of the 16 hex glyphs
// -----------------------------------------------------------------------------
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       hit
);

    // Glyphs are unique, so at most one iteration matches.
    always_comb begin
        nibble = 4'h0;
        hit    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPHS[i]) begin
                nibble = 4'(i);
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// -----------------------------------------------------------------------------
// seg7_scan_capture
// Monitors the multiplexed 8-digit seven-segment bus, waits for each scan slot
// to settle, decodes it to a hex nibble and publishes a complete frame once all
// eight digits have been seen.
//
// Parameters
//   STABLE_CYCLES  : identical synchronized samples needed to capture (2..255)
//   TIMEOUT_CYCLES : cycles allowed to assemble a frame before discarding it
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   an_in       : in  8   anodes, active-low, bit k = digit k
//   cx_in       : in  8   cathodes, active-low, [7:1] = CA..CG, [0] = DP
//   digits      : out 32  nibble k = decoded digit k of last complete frame
//   digit_valid : out 8   digit k matched a hex glyph
//   dp          : out 8   decimal point per digit, active-high
//   frame_valid : out 1   one-cycle pulse when the outputs were just updated
//   timeout     : out 1   one-cycle pulse when a partial frame is dropped
//   err_pattern : out 1   sticky, an unrecognized glyph was captured
// Build option
//   SEG7_CAPTURE_DP_EN : when defined, DP bits are stored and published on dp;
//                        otherwise dp is tied to zero.
// -----------------------------------------------------------------------------
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic [7:0]              cx_in,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic                    frame_valid,
    output logic                    timeout,
    output logic                    err_pattern
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    // The counter is cleared on the first sample of a new value and counts the
    // unchanged samples after it; capture happens on the cycle it would step
    // to STABLE_CYCLES-1, i.e. on the STABLE_CYCLES-th identical sample.
    localparam logic [7:0]    STABLE_LAST = 8'(STABLE_CYCLES - 2);

    // ---------------- input synchronizers ----------------
    logic [NUM_DIGITS-1:0] an_m, an_s, an_prev;
    logic [7:0]            cx_m, cx_s, cx_prev;

    // Idle value is "all lines high" (blank), so reset there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_m    <= '1;
            an_s    <= '1;
            cx_m    <= '1;
            cx_s    <= '1;
            an_prev <= '1;
            cx_prev <= '1;
        end else begin
            an_m    <= an_in;
            an_s    <= an_m;
            cx_m    <= cx_in;
            cx_s    <= cx_m;
            an_prev <= an_s;
            cx_prev <= cx_s;
        end
    end

    logic changed, an_ok;
    assign changed = ({an_s, cx_s} != {an_prev, cx_prev});
    assign an_ok   = an_one_hot_low(an_s);

    // ---------------- glyph decode ----------------
    logic [3:0] dec_nib;
    logic       dec_hit;

    seg7_glyph_decode u_decode (
        .pattern (cx_s[7:1]),
        .nibble  (dec_nib),
        .hit     (dec_hit)
    );

    // ---------------- capture FSM ----------------
    state_t     state, state_nx;
    logic [7:0] stable_cnt;
    logic       capture, cnt_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT:   if (an_ok) state_nx = SETTLE;
            SETTLE: begin
                if (changed)                        state_nx = an_ok ? SETTLE : WAIT;
                else if (stable_cnt == STABLE_LAST) state_nx = HOLD;
            end
            HOLD:   if (changed) state_nx = an_ok ? SETTLE : WAIT;
            default: state_nx = WAIT;
        endcase
    end

    always_comb begin
        capture = (state == SETTLE) && !changed && (stable_cnt == STABLE_LAST);
        cnt_clr = (state != SETTLE) || changed || capture;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       stable_cnt <= '0;
        else if (cnt_clr) stable_cnt <= '0;
        else              stable_cnt <= stable_cnt + 8'd1;
    end

    // ---------------- shadow frame and publish ----------------
    logic [NUM_DIGITS-1:0]      cap_mask;
    logic [NUM_DIGITS-1:0][3:0] sh_nib;
    logic [NUM_DIGITS-1:0]      sh_hit;
    logic [NUM_DIGITS-1:0]      seen;
    logic [TW-1:0]              tmo_cnt;
    logic                       complete, tmo_hit;

    // Capture only fires with a one-hot-low anode, so ~an_s selects the slot.
    assign cap_mask = capture ? ~an_s : '0;
    assign complete = (seen == '1);
    // Completion takes priority over an expiring timeout.
    assign tmo_hit  = !complete && (seen != '0) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_nib <= '0;
            sh_hit <= '0;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (cap_mask[k]) begin
                    sh_nib[k] <= dec_nib;
                    sh_hit[k] <= dec_hit;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen        <= '0;
            tmo_cnt     <= '0;
            digits      <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
            err_pattern <= 1'b0;
        end else begin
            seen        <= ((complete || tmo_hit) ? '0 : seen) | cap_mask;
            frame_valid <= complete;
            timeout     <= tmo_hit;
            if (complete || tmo_hit || seen == '0) tmo_cnt <= '0;
            else                                  tmo_cnt <= tmo_cnt + 1'b1;
            if (complete) begin
                digits      <= sh_nib;
                digit_valid <= sh_hit;
            end
            if (capture && !dec_hit) err_pattern <= 1'b1;
        end
    end

`ifdef SEG7_CAPTURE_DP_EN
    logic [NUM_DIGITS-1:0] sh_dp;

    // Pin DP is active-low; stored and published active-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_dp <= '0;
            dp    <= '0;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++)
                if (cap_mask[k]) sh_dp[k] <= ~cx_s[0];
            if (complete) dp <= sh_dp;
        end
    end
`else
    assign dp = '0;
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

    localparam int STABLE = 16;
    localparam int TMO    = 1000;
    localparam int DWELL  = 64;
`ifdef SEG7_CAPTURE_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  an_in, cx_in;
    logic [31:0] digits;
    logic [7:0]  digit_valid, dp;
    logic        frame_valid, timeout, err_pattern;

    always #5 clk = ~clk;

    seg7_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .an_in(an_in), .cx_in(cx_in),
        .digits(digits), .digit_valid(digit_valid), .dp(dp),
        .frame_valid(frame_valid), .timeout(timeout), .err_pattern(err_pattern)
    );

    // Hand-written active-low CA..CG patterns for 0..F.
    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        bit          is_tmo;
        logic [31:0] d;
        logic [7:0]  v;
        logic [7:0]  p;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_d = '0;
    logic [7:0]  last_v = '0, last_p = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [31:0] d, input logic [7:0] v, input logic [7:0] p);
        exp_t e;
        e.is_tmo = 1'b0;
        e.d = d;
        e.v = v;
        e.p = DP_EN ? p : 8'h00;
        q.push_back(e);
        last_d = e.d; last_v = e.v; last_p = e.p;
    endtask

    task automatic expect_timeout();
        exp_t e;
        e.is_tmo = 1'b1;
        e.d = last_d;
        e.v = last_v;
        e.p = last_p;
        q.push_back(e);
    endtask

    // Monitor: every output event is matched against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && (frame_valid || timeout)) begin
            check("fv_tmo_overlap", {31'b0, frame_valid & timeout}, 32'd0);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got fv=%0b tmo=%0b expected none", frame_valid, timeout);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("event_kind", {31'b0, timeout}, {31'b0, e.is_tmo});
                check("digits", digits, e.d);
                check("digit_valid", {24'b0, digit_valid}, {24'b0, e.v});
                check("dp", {24'b0, dp}, {24'b0, e.p});
            end
        end
    end

    task automatic hold(input logic [7:0] an, input logic [7:0] cx, input int n);
        an_in = an;
        cx_in = cx;
        repeat (n) @(posedge clk);
    endtask

    // Scan digits 0..n-1; slots in blank get all segments off.
    task automatic scan(input logic [31:0] vals, input logic [7:0] blank,
                        input logic [7:0] dpm, input int n);
        for (int k = 0; k < n; k++) begin
            logic [7:0] cx;
            cx = blank[k] ? 8'hFF : {glyph[vals[k*4 +: 4]], ~dpm[k]};
            hold(~(8'h01 << k), cx, DWELL);
        end
        hold(8'hFF, 8'hFF, 30);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish expected finish within time bound");
        $fatal(1);
    end

    initial begin
        an_in = 8'hFF;
        cx_in = 8'hFF;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_digits", digits, 32'd0);
        check("rst_dv", {24'b0, digit_valid}, 32'd0);
        check("rst_dp", {24'b0, dp}, 32'd0);
        check("rst_fv", {31'b0, frame_valid}, 32'd0);
        check("rst_tmo", {31'b0, timeout}, 32'd0);
        check("rst_err", {31'b0, err_pattern}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Clean scan 1..8 with DP lit on digit 5.
        expect_frame(32'h8765_4321, 8'hFF, 8'h20);
        scan(32'h8765_4321, 8'h00, 8'h20, 8);
        check("clean_err", {31'b0, err_pattern}, 32'd0);

        // Glitch on AN2: D, 10 cycles of 8, then D again.
        expect_frame(32'h09AB_CDEF, 8'hFF, 8'h00);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] vals;
            logic [7:0]  an, cx;
            vals = 32'h09AB_CDEF;
            an   = ~(8'h01 << k);
            cx   = {glyph[vals[k*4 +: 4]], 1'b1};
            if (k == 2) begin
                hold(an, cx, 10);
                hold(an, {glyph[8], 1'b1}, 10);
                hold(an, cx, DWELL - 20);
            end else begin
                hold(an, cx, DWELL);
            end
        end
        hold(8'hFF, 8'hFF, 30);

        // Blank glyph on AN3 -> miss; error stays sticky over a clean frame.
        expect_frame(32'h8765_0321, 8'hF7, 8'h00);
        scan(32'h8765_4321, 8'h08, 8'h00, 8);
        check("err_set", {31'b0, err_pattern}, 32'd1);
        expect_frame(32'h1111_1111, 8'hFF, 8'h00);
        scan(32'h1111_1111, 8'h00, 8'h00, 8);
        check("err_sticky", {31'b0, err_pattern}, 32'd1);

        // Invalid anode patterns: nothing captured, so no frame and no timeout.
        hold(8'hFC, {glyph[5], 1'b1}, 100);
        hold(8'hFF, {glyph[5], 1'b1}, 100);
        hold(8'hFF, 8'hFF, 1100);
        check("invalid_an_quiet", q.size(), 32'd0);
        check("invalid_an_digits", digits, 32'h1111_1111);

        // Partial scans of AN0..AN6: one timeout each, outputs unchanged.
        for (int r = 0; r < 2; r++) begin
            expect_timeout();
            scan(32'h0765_4321, 8'h00, 8'h00, 7);
            hold(8'hFF, 8'hFF, 700);
        end
        check("tmo_digits_kept", digits, 32'h1111_1111);
        check("tmo_dv_kept", {24'b0, digit_valid}, 32'h0000_00FF);

        // Reset after 5 captured slots, then a full scan.
        scan(32'hEEEE_EEEE, 8'h00, 8'h00, 5);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_digits", digits, 32'd0);
        check("midrst_dv", {24'b0, digit_valid}, 32'd0);
        check("midrst_err", {31'b0, err_pattern}, 32'd0);
        check("midrst_fv", {31'b0, frame_valid}, 32'd0);
        rst_n = 1'b1;
        last_d = '0; last_v = '0; last_p = '0;
        expect_frame(32'h7654_3210, 8'hFF, 8'h00);
        scan(32'h7654_3210, 8'h00, 8'h00, 8);

        repeat (50) @(posedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
